// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: show-ahead read port,
// sticky overrun flag and a level interrupt on fill threshold or overrun.
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int THRESH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [DATA_BITS-1:0]   rx_data,
    input  logic                   rd_en,
    input  logic                   clr_overrun,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    output logic                   irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wp;
    logic [AW-1:0]        r_rp;
    logic [CW-1:0]        r_count;
    logic                 r_overrun;

    logic w_wr;
    logic w_rd;
    logic w_drop;

    // A read at full frees the slot the simultaneous write needs.
    assign w_rd   = rd_en && !empty;
    assign w_wr   = rx_valid && (!full || rd_en);
    assign w_drop = rx_valid && full && !rd_en;

    // NOTE: the array has no reset; emptiness is defined by count/pointers
    // alone, so clearing the storage would buy nothing but reset fan-out.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= rx_data;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every update
    // sees the pre-edge values of count, full and empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_rd) begin
                r_rp <= r_rp + AW'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - CW'(1);
            end
            // A new drop outranks a clear in the same cycle.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rd_data = r_mem[r_rp];
    assign count   = r_count;
    assign empty   = (r_count == '0);
    assign full    = (r_count == CW'(DEPTH));
    assign overrun = r_overrun;
    assign irq     = (r_count >= CW'(THRESH)) || r_overrun;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures every byte the receiver delivers with its one-cycle `rx_valid` strobe and holds the bytes in order in a circular FIFO. The CPU drains the FIFO through a show-ahead read port. The block also keeps a sticky overrun flag and drives a level interrupt, so received bytes are not lost between CPU polls.

## Interface
- `DATA_BITS`, 8: byte width; matches the receiver's data width.
- `DEPTH`, 16: number of entries; a power of two, at least 2.
- `THRESH`, 8: fill level at or above which `irq` asserts; range 1..DEPTH.
- `CW`, $clog2(DEPTH)+1: width of `count` (derived; not overridden).

Ports:
- `clk`  in  1: system clock, 100 MHz.
- `reset`  in  1: asynchronous, active-low reset.
- `rx_valid`  in  1: one-cycle strobe from the UART receiver; a byte is present.
- `rx_data`  in  DATA_BITS: received byte; sampled only when `rx_valid`=1.
- `rd_en`  in  1: CPU pop request; acts only when `empty`=0.
- `clr_overrun`  in  1: one-cycle pulse that clears `overrun`.
- `rd_data`  out  DATA_BITS: head entry (show-ahead); valid while `empty`=0.
- `empty`  out  1: FIFO holds 0 entries.
- `full`  out  1: FIFO holds DEPTH entries.
- `count`  out  CW: current occupancy, 0..DEPTH.
- `overrun`  out  1: sticky; a byte was dropped because the FIFO was full.
- `irq`  out  1: equals (`count` ≥ THRESH) OR `overrun`.

## Operation
- Storage is a register array `mem[DEPTH]` plus write pointer `wp`, read pointer `rp` (each log2(DEPTH) bits) and an occupancy counter `count`.
- Pointers wrap modulo DEPTH by natural overflow; no comparison logic is used for wrap.
- Write condition: `rx_valid` && (!`full` || `rd_en`).
  - On a write: `mem[wp]` ← `rx_data`, then `wp` increments.
- Read condition: `rd_en` && !`empty`.
  - On a read: `rp` increments.
  - `rd_en` while empty is ignored: no pointer movement, no error flag.
- `count` update per cycle:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- Full and empty are derived from the count: `empty` = (`count`==0), `full` = (`count`==DEPTH).
- Simultaneous events:
  - Full + `rx_valid` + `rd_en`: the read frees a slot, the write is accepted, `count` stays at DEPTH, and no overrun is flagged.
  - Empty + `rx_valid` + `rd_en`: the read is ignored, the write is accepted, and `count` becomes 1.
- Overrun: `rx_valid` && `full` && !`rd_en`.
  - The byte is discarded and the FIFO contents are untouched.
  - `overrun` is set to 1 and stays set until cleared.
  - If `clr_overrun` and a new overrun occur in the same cycle, the set wins.
- `rd_data` = `mem[rp]` (combinational from the array). It is undefined when `empty`=1; the bench must not check it then.
- `irq` is combinational from the registered `count` and `overrun`.

## Timing
- Reset (`reset`=0, asynchronous) forces the following immediately, independent of `clk`:
  - `wp`=`rp`=0, `count`=0, `overrun`=0.
  - `empty`=1, `full`=0, `irq`=0.
  - `rd_data` is undefined.
  - `mem` is not cleared.
- Reset release is synchronised by the system. The first edge after release may capture a write.
- Reset asserted mid-operation discards all stored bytes; the FIFO is empty immediately.
- Write latency: a `rx_valid` sampled at edge N gives `empty`=0, `rd_data`=the byte, and `count` updated, all visible after edge N. No extra pipeline stage.
- Read latency: a `rd_en` sampled at edge N makes the next entry appear on `rd_data` after edge N.
- Back-to-back `rx_valid` on consecutive cycles is supported, although the receiver never produces it.
- Sustained read and write in the same cycle has a throughput of one byte per cycle each way.

## Test plan
- Reset and single byte:
  - Assert `reset`=0 mid-clock → `empty`=1, `count`=0, `irq`=0 at once.
  - Release, then strobe 0xA5 → next cycle `empty`=0, `rd_data`=0xA5, `count`=1.
  - `rd_en` → `empty`=1.
- Fill, threshold and overrun (DEPTH=16, THRESH=8):
  - Write 0x00..0x0F → `irq` rises after the 8th write; `full`=1 after the 16th.
  - 17th write 0xFF → `overrun`=1, `count`=16.
  - Drain all 16 → bytes read back as 0x00..0x0F, with 0xFF absent.
- Simultaneous at boundaries:
  - At full, `rx_valid`+`rd_en` with 0x55 → `overrun` stays 0, `count`=16, and 0x55 is read last.
  - At empty, `rx_valid`+`rd_en` with 0x3C → `count`=1, `rd_data`=0x3C.
- Pointer wrap:
  - Run 40 interleaved write/read pairs with an incrementing pattern → every byte is read in order, and `count` never exceeds 2.
- Overrun clear priority:
  - With `overrun`=1, pulse `clr_overrun` → `overrun`=0 and `irq` follows `count`.
  - At full, pulse `clr_overrun` in the same cycle as a dropped byte → `overrun` stays 1.
- Reset mid-stream:
  - With 5 bytes stored, pulse `reset` low → `count`=0 and `empty`=1 immediately.
  - Then write 0x11 → `rd_data`=0x11.
